// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator. A clock divider produces a
//   one-clk pixel strobe (p_tick) every DIV clocks. Horizontal and vertical
//   raster counters advance on that strobe, and sync, blanking and line/frame
//   end strobes are decoded from the counter values.
//
//   Optional feature macro: VGA_TG_RGB_PIPE_EN
//     undefined : video_on/hsync/vsync are a zero-latency combinational decode
//                 of x/y. There are no RGB ports.
//     defined   : video_on/hsync/vsync are registered on p_tick, which delays
//                 them by one pixel. rgb_in is captured on the same edge,
//                 blanked outside the active area, and driven on rgb_out.
//
//   Ports
//     clk_50MHz  in   system clock
//     reset_n    in   asynchronous active-low reset
//     enable     in   run enable; low holds the raster at the origin
//     rgb_in     in   3*CW {R,G,B} from the pixel generator (macro only)
//     rgb_out    out  3*CW registered, blanked colour (macro only)
//     p_tick     out  pixel-rate strobe, one clk wide
//     x, y       out  horizontal pixel / vertical line counters
//     video_on   out  inside the active area
//     hsync      out  horizontal sync (asserted level HS_POL)
//     vsync      out  vertical sync (asserted level VS_POL)
//     line_end   out  one-clk strobe on the last pixel of a line
//     frame_end  out  one-clk strobe on the last pixel of a frame
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int DIV      = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int CW       = 10
) (
  input  logic            clk_50MHz,
  input  logic            reset_n,
  input  logic            enable,
`ifdef VGA_TG_RGB_PIPE_EN
  input  logic [3*CW-1:0] rgb_in,
  output logic [3*CW-1:0] rgb_out,
`endif
  output logic            p_tick,
  output logic [XW-1:0]   x,
  output logic [YW-1:0]   y,
  output logic            video_on,
  output logic            hsync,
  output logic            vsync,
  output logic            line_end,
  output logic            frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Divider counter is at least one bit wide so DIV=1 still elaborates.
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ONE     = 1;
  localparam int ZERO    = 0;
  localparam int DIV_M1  = DIV - 1;
  localparam int H_M1    = H_TOTAL - 1;
  localparam int V_M1    = V_TOTAL - 1;
  localparam int HS_B    = H_ACTIVE + H_FP;
  localparam int HS_E    = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_B    = V_ACTIVE + V_FP;
  localparam int VS_E    = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [DW-1:0] DIV_LAST = DIV_M1[DW-1:0];
  localparam logic [DW-1:0] DIV_ONE  = ONE[DW-1:0];
  localparam logic [DW-1:0] DIV_ZERO = ZERO[DW-1:0];
  localparam logic [XW-1:0] X_LAST   = H_M1[XW-1:0];
  localparam logic [XW-1:0] X_ONE    = ONE[XW-1:0];
  localparam logic [XW-1:0] X_ZERO   = ZERO[XW-1:0];
  localparam logic [YW-1:0] Y_LAST   = V_M1[YW-1:0];
  localparam logic [YW-1:0] Y_ONE    = ONE[YW-1:0];
  localparam logic [YW-1:0] Y_ZERO   = ZERO[YW-1:0];

  // Decode bounds carry one extra bit: a region end may equal 2^XW / 2^YW.
  localparam logic [XW:0] H_ACT_END = H_ACTIVE[XW:0];
  localparam logic [XW:0] HS_BEGIN  = HS_B[XW:0];
  localparam logic [XW:0] HS_END    = HS_E[XW:0];
  localparam logic [YW:0] V_ACT_END = V_ACTIVE[YW:0];
  localparam logic [YW:0] VS_BEGIN  = VS_B[YW:0];
  localparam logic [YW:0] VS_END    = VS_E[YW:0];

  localparam logic HS_ON = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ON = (VS_POL != 0) ? 1'b1 : 1'b0;

  logic [DW-1:0] div_cnt;
  logic [XW:0]   x_ext;
  logic [YW:0]   y_ext;
  logic          dec_video_on;
  logic          dec_hsync;
  logic          dec_vsync;

  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};

  // Pixel divider: p_tick is registered from the terminal count, so the first
  // strobe after enable rises lands exactly DIV clocks later.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= DIV_ZERO;
      p_tick  <= 1'b0;
    end else if (!enable) begin
      div_cnt <= DIV_ZERO;
      p_tick  <= 1'b0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= DIV_ZERO;
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
      p_tick <= (div_cnt == DIV_LAST);
    end
  end

  // Raster counters. A falling enable takes priority over a coincident
  // p_tick, so the raster never steps away from the origin on that edge.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      x <= X_ZERO;
      y <= Y_ZERO;
    end else if (!enable) begin
      x <= X_ZERO;
      y <= Y_ZERO;
    end else if (p_tick) begin
      if (x == X_LAST) begin
        x <= X_ZERO;
        if (y == Y_LAST) begin
          y <= Y_ZERO;
        end else begin
          y <= y + Y_ONE;
        end
      end else begin
        x <= x + X_ONE;
      end
    end
  end

  // Region decode of the current raster position.
  always_comb begin
    dec_video_on = 1'b0;
    dec_hsync    = ~HS_ON;
    dec_vsync    = ~VS_ON;
    if ((x_ext < H_ACT_END) && (y_ext < V_ACT_END)) begin
      dec_video_on = 1'b1;
    end else begin
      dec_video_on = 1'b0;
    end
    if ((x_ext >= HS_BEGIN) && (x_ext < HS_END)) begin
      dec_hsync = HS_ON;
    end else begin
      dec_hsync = ~HS_ON;
    end
    if ((y_ext >= VS_BEGIN) && (y_ext < VS_END)) begin
      dec_vsync = VS_ON;
    end else begin
      dec_vsync = ~VS_ON;
    end
  end

  assign line_end  = p_tick & (x == X_LAST);
  assign frame_end = line_end & (y == Y_LAST);

`ifdef VGA_TG_RGB_PIPE_EN
  // Pixel-aligned output stage: colour, blanking and syncs share one capture
  // edge, so they reach the pins together one pixel after x/y.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      video_on <= 1'b0;
      hsync    <= ~HS_ON;
      vsync    <= ~VS_ON;
      rgb_out  <= {(3*CW){1'b0}};
    end else if (p_tick) begin
      video_on <= dec_video_on;
      hsync    <= dec_hsync;
      vsync    <= dec_vsync;
      rgb_out  <= dec_video_on ? rgb_in : {(3*CW){1'b0}};
    end
  end
`else
  assign video_on = dec_video_on;
  assign hsync    = dec_hsync;
  assign vsync    = dec_vsync;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen: three instances (default 640x480 geometry, a small
// mixed-polarity DIV=3 raster and the DIV=1 4/1/1/1 x 2/1/1/1 raster) share
// clock, reset and enable. A reference model tracks only the number of enabled
// clocks since the last clear and derives every expected output arithmetically.
module tb_vga_timing_gen;

  localparam int ND = 3;
  localparam int P_DIV [ND] = '{2, 3, 1};
  localparam int P_HA  [ND] = '{640, 10, 4};
  localparam int P_HF  [ND] = '{16, 2, 1};
  localparam int P_HS  [ND] = '{96, 3, 1};
  localparam int P_HB  [ND] = '{48, 2, 1};
  localparam int P_VA  [ND] = '{480, 6, 2};
  localparam int P_VF  [ND] = '{10, 1, 1};
  localparam int P_VS  [ND] = '{2, 2, 1};
  localparam int P_VB  [ND] = '{33, 2, 1};
  localparam int P_HP  [ND] = '{0, 0, 1};
  localparam int P_VP  [ND] = '{0, 1, 1};

  logic clk_50MHz = 1'b0;
  logic reset_n;
  logic enable;
  always #5 clk_50MHz = ~clk_50MHz;

  logic       d0_pt, d0_vo, d0_hs, d0_vs, d0_le, d0_fe;
  logic [9:0] d0_x, d0_y;
  logic       d1_pt, d1_vo, d1_hs, d1_vs, d1_le, d1_fe;
  logic [4:0] d1_x;
  logic [3:0] d1_y;
  logic       d2_pt, d2_vo, d2_hs, d2_vs, d2_le, d2_fe;
  logic [2:0] d2_x, d2_y;
`ifdef VGA_TG_RGB_PIPE_EN
  logic [29:0] rgb_in;
  logic [29:0] o_rgb [ND];
`endif

  vga_timing_gen #(.DIV(P_DIV[0]), .H_ACTIVE(P_HA[0]), .H_FP(P_HF[0]), .H_SYNC(P_HS[0]), .H_BP(P_HB[0]),
    .V_ACTIVE(P_VA[0]), .V_FP(P_VF[0]), .V_SYNC(P_VS[0]), .V_BP(P_VB[0]), .HS_POL(P_HP[0]), .VS_POL(P_VP[0]),
    .XW(10), .YW(10), .CW(10)) dut0 (
    .clk_50MHz(clk_50MHz), .reset_n(reset_n), .enable(enable),
`ifdef VGA_TG_RGB_PIPE_EN
    .rgb_in(rgb_in), .rgb_out(o_rgb[0]),
`endif
    .p_tick(d0_pt), .x(d0_x), .y(d0_y), .video_on(d0_vo), .hsync(d0_hs), .vsync(d0_vs),
    .line_end(d0_le), .frame_end(d0_fe));

  vga_timing_gen #(.DIV(P_DIV[1]), .H_ACTIVE(P_HA[1]), .H_FP(P_HF[1]), .H_SYNC(P_HS[1]), .H_BP(P_HB[1]),
    .V_ACTIVE(P_VA[1]), .V_FP(P_VF[1]), .V_SYNC(P_VS[1]), .V_BP(P_VB[1]), .HS_POL(P_HP[1]), .VS_POL(P_VP[1]),
    .XW(5), .YW(4), .CW(10)) dut1 (
    .clk_50MHz(clk_50MHz), .reset_n(reset_n), .enable(enable),
`ifdef VGA_TG_RGB_PIPE_EN
    .rgb_in(rgb_in), .rgb_out(o_rgb[1]),
`endif
    .p_tick(d1_pt), .x(d1_x), .y(d1_y), .video_on(d1_vo), .hsync(d1_hs), .vsync(d1_vs),
    .line_end(d1_le), .frame_end(d1_fe));

  vga_timing_gen #(.DIV(P_DIV[2]), .H_ACTIVE(P_HA[2]), .H_FP(P_HF[2]), .H_SYNC(P_HS[2]), .H_BP(P_HB[2]),
    .V_ACTIVE(P_VA[2]), .V_FP(P_VF[2]), .V_SYNC(P_VS[2]), .V_BP(P_VB[2]), .HS_POL(P_HP[2]), .VS_POL(P_VP[2]),
    .XW(3), .YW(3), .CW(10)) dut2 (
    .clk_50MHz(clk_50MHz), .reset_n(reset_n), .enable(enable),
`ifdef VGA_TG_RGB_PIPE_EN
    .rgb_in(rgb_in), .rgb_out(o_rgb[2]),
`endif
    .p_tick(d2_pt), .x(d2_x), .y(d2_y), .video_on(d2_vo), .hsync(d2_hs), .vsync(d2_vs),
    .line_end(d2_le), .frame_end(d2_fe));

  // Uniform per-instance views of the outputs.
  logic o_pt [ND], o_vo [ND], o_hs [ND], o_vs [ND], o_le [ND], o_fe [ND];
  int   o_x [ND], o_y [ND];
  assign o_pt[0] = d0_pt; assign o_pt[1] = d1_pt; assign o_pt[2] = d2_pt;
  assign o_vo[0] = d0_vo; assign o_vo[1] = d1_vo; assign o_vo[2] = d2_vo;
  assign o_hs[0] = d0_hs; assign o_hs[1] = d1_hs; assign o_hs[2] = d2_hs;
  assign o_vs[0] = d0_vs; assign o_vs[1] = d1_vs; assign o_vs[2] = d2_vs;
  assign o_le[0] = d0_le; assign o_le[1] = d1_le; assign o_le[2] = d2_le;
  assign o_fe[0] = d0_fe; assign o_fe[1] = d1_fe; assign o_fe[2] = d2_fe;
  assign o_x[0] = int'(d0_x); assign o_x[1] = int'(d1_x); assign o_x[2] = int'(d2_x);
  assign o_y[0] = int'(d0_y); assign o_y[1] = int'(d1_y); assign o_y[2] = int'(d2_y);

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // n = number of consecutive enabled clock edges since reset or enable low.
  longint n;

  function automatic int ht(int i); return P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i]; endfunction
  function automatic int vt(int i); return P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i]; endfunction
  function automatic logic tick_at(longint nn, int i); return (nn > 0) && ((nn % P_DIV[i]) == 0); endfunction
  // Pixels completed: one per strobe seen before the current edge.
  function automatic longint pix_at(longint nn, int i); return (nn < 1) ? 0 : (nn - 1) / P_DIV[i]; endfunction
  function automatic int x_at(longint nn, int i); return int'(pix_at(nn, i) % ht(i)); endfunction
  function automatic int y_at(longint nn, int i); return int'((pix_at(nn, i) / ht(i)) % vt(i)); endfunction
  function automatic logic vo_at(longint nn, int i);
    return (x_at(nn, i) < P_HA[i]) && (y_at(nn, i) < P_VA[i]);
  endfunction
  function automatic logic hs_at(longint nn, int i);
    int xx = x_at(nn, i);
    logic pol = (P_HP[i] != 0);
    return ((xx >= P_HA[i] + P_HF[i]) && (xx < P_HA[i] + P_HF[i] + P_HS[i])) ? pol : ~pol;
  endfunction
  function automatic logic vs_at(longint nn, int i);
    int yy = y_at(nn, i);
    logic pol = (P_VP[i] != 0);
    return ((yy >= P_VA[i] + P_VF[i]) && (yy < P_VA[i] + P_VF[i] + P_VS[i])) ? pol : ~pol;
  endfunction
  function automatic logic le_at(longint nn, int i); return tick_at(nn, i) && (x_at(nn, i) == ht(i) - 1); endfunction
  function automatic logic fe_at(longint nn, int i); return le_at(nn, i) && (y_at(nn, i) == vt(i) - 1); endfunction

`ifdef VGA_TG_RGB_PIPE_EN
  logic        r_vo [ND], r_hs [ND], r_vs [ND];
  logic [29:0] r_rgb [ND];
  function automatic logic exp_vo(int i); return r_vo[i]; endfunction
  function automatic logic exp_hs(int i); return r_hs[i]; endfunction
  function automatic logic exp_vs(int i); return r_vs[i]; endfunction
  localparam logic RST_VO = 1'b0;
`else
  function automatic logic exp_vo(int i); return vo_at(n, i); endfunction
  function automatic logic exp_hs(int i); return hs_at(n, i); endfunction
  function automatic logic exp_vs(int i); return vs_at(n, i); endfunction
  localparam logic RST_VO = 1'b1;
`endif

  always @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      n <= 0;
`ifdef VGA_TG_RGB_PIPE_EN
      for (int i = 0; i < ND; i++) begin
        r_vo[i] <= 1'b0; r_hs[i] <= (P_HP[i] == 0); r_vs[i] <= (P_VP[i] == 0); r_rgb[i] <= 30'd0;
      end
`endif
    end else begin
`ifdef VGA_TG_RGB_PIPE_EN
      for (int i = 0; i < ND; i++) begin
        if (tick_at(n, i)) begin
          r_vo[i] <= vo_at(n, i); r_hs[i] <= hs_at(n, i); r_vs[i] <= vs_at(n, i);
          r_rgb[i] <= vo_at(n, i) ? rgb_in : 30'd0;
        end
      end
`endif
      n <= enable ? n + 1 : 0;
    end
  end

  // ---------------- tests ----------------
  // Assert reset between clock edges, check the asynchronous response and that
  // it holds across edges, then release with enable high.
  task automatic test_reset(input string tag);
    @(negedge clk_50MHz);
    #2 reset_n = 1'b0;
    enable = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) #1; else repeat (2) @(negedge clk_50MHz);
      for (int i = 0; i < ND; i++) begin
        checks++; if (o_pt[i] !== 1'b0) begin errors++; $display("FAIL %s_ptick dut%0d got=%b exp=0", tag, i, o_pt[i]); end
        checks++; if (o_x[i] !== 0) begin errors++; $display("FAIL %s_x dut%0d got=%0d exp=0", tag, i, o_x[i]); end
        checks++; if (o_y[i] !== 0) begin errors++; $display("FAIL %s_y dut%0d got=%0d exp=0", tag, i, o_y[i]); end
        checks++; if (o_vo[i] !== RST_VO) begin errors++; $display("FAIL %s_video_on dut%0d got=%b exp=%b", tag, i, o_vo[i], RST_VO); end
        checks++; if (o_hs[i] !== (P_HP[i] == 0)) begin errors++; $display("FAIL %s_hsync dut%0d got=%b exp=%b", tag, i, o_hs[i], (P_HP[i] == 0)); end
        checks++; if (o_vs[i] !== (P_VP[i] == 0)) begin errors++; $display("FAIL %s_vsync dut%0d got=%b exp=%b", tag, i, o_vs[i], (P_VP[i] == 0)); end
        checks++; if (o_le[i] !== 1'b0 || o_fe[i] !== 1'b0) begin errors++; $display("FAIL %s_strobes dut%0d got=%b%b exp=00", tag, i, o_le[i], o_fe[i]); end
`ifdef VGA_TG_RGB_PIPE_EN
        checks++; if (o_rgb[i] !== 30'd0) begin errors++; $display("FAIL %s_rgb dut%0d got=%h exp=0", tag, i, o_rgb[i]); end
`endif
      end
    end
    @(negedge clk_50MHz);
    reset_n = 1'b1;
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  task automatic test_raster(input string tag, input int cycles, input bit rand_en);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_50MHz);
      for (int i = 0; i < ND; i++) begin
        checks++; if (o_pt[i] !== tick_at(n, i)) begin errors++; $display("FAIL %s_ptick dut%0d t=%0t got=%b exp=%b", tag, i, $time, o_pt[i], tick_at(n, i)); end
        checks++; if (o_x[i] !== x_at(n, i)) begin errors++; $display("FAIL %s_x dut%0d t=%0t got=%0d exp=%0d", tag, i, $time, o_x[i], x_at(n, i)); end
        checks++; if (o_y[i] !== y_at(n, i)) begin errors++; $display("FAIL %s_y dut%0d t=%0t got=%0d exp=%0d", tag, i, $time, o_y[i], y_at(n, i)); end
        checks++; if (o_vo[i] !== exp_vo(i)) begin errors++; $display("FAIL %s_video_on dut%0d t=%0t got=%b exp=%b", tag, i, $time, o_vo[i], exp_vo(i)); end
        checks++; if (o_hs[i] !== exp_hs(i)) begin errors++; $display("FAIL %s_hsync dut%0d t=%0t got=%b exp=%b", tag, i, $time, o_hs[i], exp_hs(i)); end
        checks++; if (o_vs[i] !== exp_vs(i)) begin errors++; $display("FAIL %s_vsync dut%0d t=%0t got=%b exp=%b", tag, i, $time, o_vs[i], exp_vs(i)); end
        checks++; if (o_le[i] !== le_at(n, i)) begin errors++; $display("FAIL %s_line_end dut%0d t=%0t got=%b exp=%b", tag, i, $time, o_le[i], le_at(n, i)); end
        checks++; if (o_fe[i] !== fe_at(n, i)) begin errors++; $display("FAIL %s_frame_end dut%0d t=%0t got=%b exp=%b", tag, i, $time, o_fe[i], fe_at(n, i)); end
`ifdef VGA_TG_RGB_PIPE_EN
        checks++; if (o_rgb[i] !== r_rgb[i]) begin errors++; $display("FAIL %s_rgb dut%0d t=%0t got=%h exp=%h", tag, i, $time, o_rgb[i], r_rgb[i]); end
`endif
      end
      if (rand_en) begin
        enable = ($urandom_range(0, 15) != 0);
`ifdef VGA_TG_RGB_PIPE_EN
        rgb_in = 30'($urandom);
`endif
      end
    end
  endtask

  // Period and pulse-width measurements straight from the geometry numbers.
  task automatic test_geometry();
    int last_pt0 = -1, last_le0 = -1, last_fe1 = -1, last_le2 = -1, last_fe2 = -1;
    int hs0 = 0, vo0 = 0, vs1 = 0, hs2 = 0, pt2_gap = 0;
    bit pt2_seen = 1'b0;
    for (int cyc = 0; cyc < 3400; cyc++) begin
      @(negedge clk_50MHz);
      if (d0_pt) begin
        if (last_pt0 >= 0) begin checks++; if (cyc - last_pt0 != 2) begin errors++; $display("FAIL geo_ptick_period got=%0d exp=2", cyc - last_pt0); end end
        last_pt0 = cyc;
      end
      if (!d0_hs) hs0++;
      if (d0_vo) vo0++;
      if (d0_le) begin
        if (last_le0 >= 0) begin checks++; if (cyc - last_le0 != 1600) begin errors++; $display("FAIL geo_line_period got=%0d exp=1600", cyc - last_le0); end end
        checks++; if (hs0 != 192) begin errors++; $display("FAIL geo_hsync_width got=%0d exp=192", hs0); end
        checks++; if (vo0 != 1280) begin errors++; $display("FAIL geo_video_on_width got=%0d exp=1280", vo0); end
        hs0 = 0; vo0 = 0; last_le0 = cyc;
      end
      if (d1_vs) vs1++;
      if (d1_fe) begin
        if (last_fe1 >= 0) begin checks++; if (cyc - last_fe1 != 561) begin errors++; $display("FAIL geo_frame_period_dut1 got=%0d exp=561", cyc - last_fe1); end end
        checks++; if (vs1 != 102) begin errors++; $display("FAIL geo_vsync_width_dut1 got=%0d exp=102", vs1); end
        vs1 = 0; last_fe1 = cyc;
      end
      if (d2_pt) pt2_seen = 1'b1; else if (pt2_seen) pt2_gap++;
      if (d2_hs) hs2++;
      if (d2_le) begin
        if (last_le2 >= 0) begin checks++; if (cyc - last_le2 != 7) begin errors++; $display("FAIL geo_line_period_dut2 got=%0d exp=7", cyc - last_le2); end end
        checks++; if (hs2 != 1) begin errors++; $display("FAIL geo_hsync_width_dut2 got=%0d exp=1", hs2); end
        hs2 = 0; last_le2 = cyc;
      end
      if (d2_fe) begin
        if (last_fe2 >= 0) begin checks++; if (cyc - last_fe2 != 35) begin errors++; $display("FAIL geo_frame_period_dut2 got=%0d exp=35", cyc - last_fe2); end end
        last_fe2 = cyc;
      end
    end
    checks++; if (!pt2_seen || pt2_gap != 0) begin errors++; $display("FAIL geo_ptick_const_dut2 seen=%b gaps=%0d exp seen=1 gaps=0", pt2_seen, pt2_gap); end
    checks++; if (last_le0 != 3199) begin errors++; $display("FAIL geo_line_end_pos got=%0d exp=3199", last_le0); end
  endtask

  // Drop enable at x=300 for 10 clocks, then measure the restart latency.
  task automatic test_enable_drop();
    int k = 0;
    int first [ND];
    while (d0_x != 10'd300 && k < 2000) begin @(negedge clk_50MHz); k++; end
    checks++; if (k >= 2000) begin errors++; $display("FAIL drop_wait_x300 got=timeout exp=x300"); end
    enable = 1'b0;
    repeat (10) begin
      @(negedge clk_50MHz);
      for (int i = 0; i < ND; i++) begin
        checks++; if (o_x[i] !== 0 || o_y[i] !== 0) begin errors++; $display("FAIL drop_hold dut%0d got=(%0d,%0d) exp=(0,0)", i, o_x[i], o_y[i]); end
        checks++; if (o_pt[i] !== 1'b0 || o_le[i] !== 1'b0) begin errors++; $display("FAIL drop_ptick dut%0d got=%b%b exp=00", i, o_pt[i], o_le[i]); end
      end
    end
    enable = 1'b1;
    for (int i = 0; i < ND; i++) first[i] = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_50MHz);
      for (int i = 0; i < ND; i++) begin
        if (first[i] < 0) begin
          checks++; if (o_x[i] !== 0) begin errors++; $display("FAIL rise_x dut%0d got=%0d exp=0", i, o_x[i]); end
          if (o_pt[i] === 1'b1) first[i] = c;
        end
      end
    end
    for (int i = 0; i < ND; i++) begin
      checks++; if (first[i] != P_DIV[i]) begin errors++; $display("FAIL rise_first_ptick dut%0d got=%0d exp=%0d", i, first[i], P_DIV[i]); end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    enable  = 1'b0;
`ifdef VGA_TG_RGB_PIPE_EN
    rgb_in  = 30'h3FFFFFFF;
`endif
    test_reset("reset_init");
    test_geometry();
    test_enable_drop();
    test_raster("after_drop", 400, 1'b0);
    test_raster("rand_en", 3000, 1'b1);
    enable = 1'b1;
`ifdef VGA_TG_RGB_PIPE_EN
    rgb_in = 30'h3FFFFFFF;
`endif
    repeat ($urandom_range(100, 900)) @(negedge clk_50MHz);
    test_reset("reset_mid");
    test_raster("after_reset", 2000, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It replaces the fixed 640x480 controller with one whose pixel divider, porch/sync geometry and sync polarities are all parameters. It adds a run enable, line/frame end strobes and an optional pixel-aligned RGB output stage. It sits between the board clock and the pixel generator: it drives `p_tick` and `x`/`y` to the pixel generator, and `hsync`/`vsync` (and `rgb_out` when enabled) to the DAC pins.

## Interface
- `DIV`, 2: clk cycles per pixel; must be ≥1. 1 means `p_tick` is tied high after reset.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal geometry in pixels.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical geometry in lines.
- `HS_POL`, `VS_POL`, 0/0: asserted sync level (0 = active-low).
- `XW`, `YW`, 10/10: coordinate widths. `H_TOTAL` must be ≤2^XW and `V_TOTAL` must be ≤2^YW.
- `CW`, 10: bits per colour channel (RGB path only).
- `clk_50MHz`  in  1  system clock.
- `reset_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `enable`  in  1  run enable. Low holds the raster at origin.
- `p_tick`  out  1  pixel-rate strobe, one clk wide.
- `x`  out  XW  horizontal pixel counter.
- `y`  out  YW  vertical line counter.
- `video_on`  out  1  inside the active area.
- `hsync`  out  1  horizontal sync.
- `vsync`  out  1  vertical sync.
- `line_end`  out  1  one-clk strobe on the last pixel of a line.
- `frame_end`  out  1  one-clk strobe on the last pixel of a frame.
- `rgb_in`  in  3*CW  {R,G,B} from the pixel generator (macro only).
- `rgb_out`  out  3*CW  registered, blanked colour (macro only).

## Operation
- Totals: `H_TOTAL` = H_ACTIVE+H_FP+H_SYNC+H_BP; `V_TOTAL` is the same sum over the V parameters.
- Divider:
  - `div_cnt` counts 0..DIV-1 while `enable`=1.
  - `p_tick` is a register, set in the clk after `div_cnt`==DIV-1, so the period is exactly DIV clks.
- Raster counters advance only in a clk where `p_tick`=1:
  - `x` increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, `y` increments and wraps from V_TOTAL-1 to 0.
- Decode (combinational from `x`/`y` when the macro is off):
  - `video_on` = (x<H_ACTIVE)&&(y<V_ACTIVE).
  - `hsync` = HS_POL when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - `vsync` is the same rule on `y` with the V parameters and VS_POL.
- Strobes (combinational):
  - `line_end` = p_tick && x==H_TOTAL-1.
  - `frame_end` = line_end && y==V_TOTAL-1.
- `enable` low:
  - Synchronously clears `div_cnt`, `p_tick`, `x` and `y` on the next clk.
  - Counters stay cleared while `enable` is low; decoded outputs follow x=y=0.
  - After `enable` rises, the first `p_tick` occurs DIV clks later.
- Reset (async, `reset_n`=0):
  - `div_cnt`, `p_tick`, `x`, `y` = 0.
  - `hsync` = ~HS_POL, `vsync` = ~VS_POL.
  - `video_on` = 1 (combinational from origin) when the macro is off; 0 when it is on.
  - `line_end`, `frame_end` = 0; `rgb_out` = 0.
- Reset release mid-line or mid-frame always restarts at the origin; no partial state survives.

## Timing
- `x`/`y` change on the clk edge where `p_tick`=1 and hold for DIV clks.
- Macro off: sync and `video_on` are valid in the same clk as the `x`/`y` they decode (zero latency).
- Macro on: `video_on`, `hsync` and `vsync` are each registered on `p_tick`, a one-pixel delay. This aligns them with `rgb_out`, which is captured on the same edge.
- Simultaneous `enable` fall and `p_tick`: the clear wins, and the counters do not advance.

## Configuration
- `VGA_TG_RGB_PIPE_EN` defined:
  - `rgb_in` and `rgb_out` ports exist.
  - On each `p_tick`, `rgb_out` ← (decoded video_on ? rgb_in : 0).
  - The sync and `video_on` outputs are the one-pixel-delayed registered versions.
  - Total latency from `x`/`y` to pins is 1 pixel.
- `VGA_TG_RGB_PIPE_EN` undefined:
  - No RGB ports.
  - Outputs are the zero-latency combinational decode.
  - RGB buffering remains the integrator's responsibility.

## Test plan
- Defaults, `enable`=1 after reset -> `p_tick` every 2 clks; `line_end` every 1600 clks; `frame_end` every 840000 clks.
- Defaults, macro off -> `hsync` low for x=656..751 (192 clks); `vsync` low for y=490..491 (3200 clks); `video_on` high for x<640 && y<480.
- `enable` dropped at x=300,y=100 for 10 clks, then raised -> x=y=0 on the next clk, held through the low period; first `p_tick` 2 clks after the rise.
- `reset_n` pulsed low mid-line -> all outputs take their reset values asynchronously; raster restarts at (0,0).
- DIV=1, H=4/1/1/1, V=2/1/1/1, HS_POL=VS_POL=1 -> `p_tick` constant high; line 7 clks; `hsync` high at x=5; `frame_end` every 35 clks.
- Macro on, `rgb_in`=3FFFFFFF constant -> `rgb_out` = all ones exactly for pixels where registered `video_on`=1, 0 elsewhere; `rgb_out` edges coincide with registered `hsync`/`vsync` edges shifted one pixel from the macro-off case.
